// File: rtl/fifo_flags.sv
// fifo_flags: single-clock FIFO with occupancy count, almost-full/almost-empty flags and sticky error flags.
// Latency: registered dout, valid one cycle after an accepted read. With FIFO_FWFT_EN defined, dout shows the head word combinationally.
// Backpressure: a write into a full FIFO is rejected unless a read is accepted in the same cycle. A read from an empty FIFO is rejected.
//
// Optional build macro: FIFO_FWFT_EN (first-word-fall-through read port).
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   wr_n, din         active-low write request and write data
//   rd_n              active-low read request / head acknowledge
//   err_clr           synchronous clear of the sticky overflow/underflow flags
//   dout              read data
//   full, empty       count == DEPTH / count == 0
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   count             current occupancy, 0..DEPTH
//   overflow          sticky: a write was rejected because the FIFO was full
//   underflow         sticky: a read was rejected because the FIFO was empty
module fifo_flags #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_n,
   input  logic                         rd_n,
   input  logic [WIDTH-1:0]             din,
   input  logic                         err_clr,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   // Thresholds at count width, so every flag compare has matching widths.
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   // almost_full out of reset follows the count==0 case. This is 0 for every legal AF_LEVEL.
   localparam logic AF_RST = (AF_LEVEL == 0) ? 1'b1 : 1'b0;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             empty_q,  empty_d;
   logic             full_q,   full_d;
   logic             afull_q,  afull_d;
   logic             aempty_q, aempty_d;
   logic             ovf_q,    ovf_d;
   logic             unf_q,    unf_d;
   logic [WIDTH-1:0] dout_q,   dout_d;

   logic             rd_acc;
   logic             wr_acc;
   logic             wr_rej;
   logic             rd_rej;

   // ------------------------------------------------------------------
   // Handshake and next-state
   // ------------------------------------------------------------------
   always_comb begin
      rd_acc   = 1'b0;
      wr_acc   = 1'b0;
      wr_rej   = 1'b0;
      rd_rej   = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;

      // A read is accepted when there is data.
      // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
      // When empty, the read is never accepted, so a simultaneous write lands and the read is counted as an underflow.
      rd_acc = !rd_n && !empty_q;
      wr_acc = !wr_n && (!full_q || rd_acc);
      wr_rej = !wr_n && !wr_acc;
      rd_rej = !rd_n && empty_q;

      // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         dout_d   = mem_q[rd_ptr_q];
      end

      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
   end

   // Flags come from the next count, so they move on the same edge as count.
   always_comb begin
      empty_d  = (count_d == '0);
      full_d   = (count_d == DEPTH_C);
      afull_d  = (count_d >= AF_C);
      aempty_d = (count_d <= AE_C);

      // A new error on the same edge as err_clr wins over the clear.
      ovf_d = wr_rej | (ovf_q & ~err_clr);
      unf_d = rd_rej | (unf_q & ~err_clr);
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= AF_RST;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         dout_q   <= dout_d;
      end
   end

   // Storage is not reset.
   // A write that coincides with reset may touch mem_q[0].
   // The pointers and count are held at zero by reset, so that word is never treated as stored.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
`ifdef FIFO_FWFT_EN
   // Head word is visible while data is present.
   // When empty, dout_q (the last popped word) is shown instead.
   assign dout = empty_q ? dout_q : mem_q[rd_ptr_q];
`else
   assign dout = dout_q;
`endif

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: self-checking bench for fifo_flags (WIDTH=8, DEPTH=16, AF=14, AE=2).
// Latency: compares DUT outputs every cycle on the falling edge against a queue-based model.
// Backpressure: directed stimulus drives full/empty boundaries, wrap-around, reset and error clear.
module tb_fifo_flags;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AFL   = 14;
   localparam int AEL   = 2;

   logic             clk;
   logic             reset;
   logic             wr_n;
   logic             rd_n;
   logic [WIDTH-1:0] din;
   logic             err_clr;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [4:0]       count;
   logic             overflow;
   logic             underflow;

   fifo_flags #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
   ) dut (
      .clk(clk), .reset(reset), .wr_n(wr_n), .rd_n(rd_n), .din(din),
      .err_clr(err_clr), .dout(dout), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Model state: the queue holds the words currently stored.
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] m_dout = '0;
   bit               m_ovf  = 1'b0;
   bit               m_unf  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic model_step(input logic w_n, input logic r_n, input logic [WIDTH-1:0] d,
                             input logic clr);
      bit was_empty, was_full, ra, wa;
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      ra = !r_n && !was_empty;
      wa = !w_n && (!was_full || ra);
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (!w_n && !wa) m_ovf = 1'b1;
      if (!r_n && was_empty) m_unf = 1'b1;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(d);
   endtask

   function automatic logic [WIDTH-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
      return (mq.size() > 0) ? mq[0] : m_dout;
`else
      return m_dout;
`endif
   endfunction

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",        32'(count),        32'(mq.size()));
         chk("empty",        32'(empty),        32'(mq.size() == 0));
         chk("full",         32'(full),         32'(mq.size() == DEPTH));
         chk("almost_full",  32'(almost_full),  32'(mq.size() >= AFL));
         chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AEL));
         chk("overflow",     32'(overflow),     32'(m_ovf));
         chk("underflow",    32'(underflow),    32'(m_unf));
         chk("dout",         32'(dout),         32'(exp_dout()));
      end
   end

   // One clock of stimulus: drive at the falling edge, update the model at the rising edge, and return at the next falling edge.
   task automatic cyc(input logic w_n, input logic r_n, input logic [WIDTH-1:0] d,
                      input logic clr);
      wr_n    = w_n;
      rd_n    = r_n;
      din     = d;
      err_clr = clr;
      @(posedge clk);
      model_step(w_n, r_n, d, clr);
      @(negedge clk);
   endtask

   logic [WIDTH-1:0] wdat [DEPTH];
   logic [WIDTH-1:0] prev;

   initial begin
      reset   = 1'b1;
      wr_n    = 1'b1;
      rd_n    = 1'b1;
      din     = '0;
      err_clr = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk_en = 1'b1;

      // Reset values, pinned literally.
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_ae",    32'(almost_empty), 1);
      chk("rst_af",    32'(almost_full), 0);
      chk("rst_dout",  32'(dout), 32'h00);

      // Reset asserted mid-cycle after 5 writes.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
      chk("pre_rst_count", 32'(count), 5);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      chk("mid_rst_ae",    32'(almost_empty), 1);
      chk("mid_rst_full",  32'(full), 0);
      chk("mid_rst_dout",  32'(dout), 32'h00);
      chk("mid_rst_ovf",   32'(overflow), 0);
      chk("mid_rst_unf",   32'(underflow), 0);
      @(negedge clk);
      reset = 1'b0;

      // Fill 16 and drain 16.
      for (int i = 0; i < DEPTH; i++) begin
         wdat[i] = 8'($urandom_range(0, 255));
         cyc(1'b0, 1'b1, wdat[i], 1'b0);
         if (i == 12) chk("af_at13", 32'(almost_full), 0);
         if (i == 13) chk("af_at14", 32'(almost_full), 1);
         if (i == 14) chk("full_at15", 32'(full), 0);
      end
      chk("full_at16", 32'(full), 1);
      for (int i = 0; i < DEPTH; i++) begin
`ifdef FIFO_FWFT_EN
         chk("fwft_head", 32'(dout), 32'(wdat[i]));
         cyc(1'b1, 1'b0, 8'h00, 1'b0);
`else
         cyc(1'b1, 1'b0, 8'h00, 1'b0);
         chk("rd_data", 32'(dout), 32'(wdat[i]));
`endif
      end
      chk("drain_empty", 32'(empty), 1);

      // Wrap-around: 10 in, 10 out, 16 in, 16 out.
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      chk("wrap_full", 32'(full), 1);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);

      // Full boundary: refill, then simultaneous read and write for 3 cycles.
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'(8'hC0 + i), 1'b0);
      chk("rw_full_count", 32'(count), 16);
      chk("rw_full_ovf",   32'(overflow), 0);
`ifndef FIFO_FWFT_EN
      chk("rw_full_oldest", 32'(dout), 32'h42);
`endif
      cyc(1'b0, 1'b1, 8'hEE, 1'b0);
      chk("ovf_set",   32'(overflow), 1);
      chk("ovf_count", 32'(count), 16);
      cyc(1'b1, 1'b1, 8'h00, 1'b1);
      chk("ovf_clr", 32'(overflow), 0);
      cyc(1'b0, 1'b1, 8'hEF, 1'b1);
      chk("ovf_set_wins", 32'(overflow), 1);
      cyc(1'b1, 1'b1, 8'h00, 1'b1);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);

      // Empty boundary: simultaneous read and write on an empty FIFO.
      prev = dout;
      cyc(1'b0, 1'b0, 8'hA5, 1'b0);
      chk("eb_count", 32'(count), 1);
      chk("eb_unf",   32'(underflow), 1);
`ifndef FIFO_FWFT_EN
      chk("eb_dout_hold", 32'(dout), 32'(prev));
`endif
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("eb_read_a5", 32'(dout), 32'hA5);
      chk("eb_empty",   32'(empty), 1);
      cyc(1'b1, 1'b1, 8'h00, 1'b1);
      chk("unf_clr", 32'(underflow), 0);

      // Single write then pop; in FWFT builds the word falls through without a read.
      cyc(1'b0, 1'b1, 8'h3C, 1'b0);
      chk("w1_empty", 32'(empty), 0);
`ifdef FIFO_FWFT_EN
      chk("fwft_3c", 32'(dout), 32'h3C);
`endif
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("pop_empty", 32'(empty), 1);
      chk("pop_count", 32'(count), 0);
      chk("pop_dout",  32'(dout), 32'h3C);

      cyc(1'b1, 1'b1, 8'h00, 1'b0);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
